// File: rtl/zcs_pkg.sv
// Shared types and width helpers for the chunked leading-zero counter.
// Both the sequencer and its combinational slice import this package.
package zcs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width needed to hold a zero count of 0..data_w inclusive.
    function automatic int out_w_f(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Width of the per-chunk count, 0..chunk_w inclusive.
    function automatic int cnt_w_f(input int chunk_w);
        return $clog2(chunk_w + 1);
    endfunction

endpackage

// File: rtl/zero_counter.sv
// Combinational leading-zero counter for one narrow slice: counts zeros
// from bit IN_W-1 downward, returning IN_W for an all-zero slice.
module zero_counter
    import zcs_pkg::*;
#(
    parameter  int IN_W  = 8,
    localparam int CNT_W = cnt_w_f(IN_W)
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] w_count;

    // Ascending scan: the last hit is the highest set bit, so no priority flag is needed.
    always_comb begin
        // NOTE: assigning a default before any conditional write keeps this block free of inferred latches.
        w_count = CNT_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            if (i_data[i]) begin
                w_count = CNT_W'(IN_W - 1 - i);
            end
        end
    end

    assign o_count = w_count;

endmodule

// File: rtl/zero_count_sequencer.sv
// Multi-cycle leading-zero counter: scans a wide word one chunk per cycle from
// the MSB end through a single shared zero_counter slice, stopping at the first one.
module zero_count_sequencer
    import zcs_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int CHUNK_W  = 8,
    localparam int N_CHUNKS = DATA_W / CHUNK_W,
    localparam int OUT_W    = out_w_f(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_count,
    output logic              out_all_zero,
    output logic              busy
);

    localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int CNT_W = cnt_w_f(CHUNK_W);

    generate
        if ((DATA_W % CHUNK_W) != 0 || N_CHUNKS < 2) begin : g_bad_params
            $error("zero_count_sequencer: DATA_W must be a multiple of CHUNK_W with at least two chunks");
        end
    endgenerate

    state_e              r_state;
    state_e              w_state_next;
    logic [DATA_W-1:0]   r_word;
    logic [IDX_W-1:0]    r_idx;
    logic [OUT_W-1:0]    r_acc;
    logic [OUT_W-1:0]    r_count;
    logic                r_all_zero;

    logic [CHUNK_W-1:0]  w_chunk;
    logic [CNT_W-1:0]    w_cnt;
    logic [OUT_W-1:0]    w_acc_next;
    logic                w_last;

    assign w_chunk = r_word[int'(r_idx) * CHUNK_W +: CHUNK_W];

    zero_counter #(
        .IN_W (CHUNK_W)
    ) u_zero_counter (
        .i_data  (w_chunk),
        .o_count (w_cnt)
    );

    // The accumulator is sized for DATA_W, so the sum of all chunk counts cannot wrap.
    assign w_acc_next = r_acc + OUT_W'(w_cnt);
    assign w_last     = (w_cnt < CNT_W'(CHUNK_W)) || (r_idx == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = SCAN;
            SCAN:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_all_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word <= in_data;
                        r_idx  <= IDX_W'(N_CHUNKS - 1);
                        r_acc  <= '0;
                    end
                end
                SCAN: begin
                    if (w_last) begin
                        r_count    <= w_acc_next;
                        r_all_zero <= (w_acc_next == OUT_W'(DATA_W));
                    end else begin
                        r_acc <= w_acc_next;
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign busy         = (r_state == SCAN);
    assign out_valid    = (r_state == DONE);
    assign out_count    = r_count;
    assign out_all_zero = r_all_zero;

endmodule

// File: tb/tb_zero_count_sequencer.sv
// Scoreboard bench for zero_count_sequencer: the driver queues hand-computed
// results, a monitor checks them against the output handshake.
module tb_zero_count_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_count;
    logic        out_all_zero;
    logic        busy;

    zero_count_sequencer #(
        .DATA_W  (32),
        .CHUNK_W (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .out_all_zero (out_all_zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] count;
        logic       all_zero;
        int         valid_cyc;
        int         lat;
        int         hold;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Present a word, wait (bounded) for acceptance, and queue its expected result.
    task automatic send(input logic [31:0] data, input int exp_cnt, input logic exp_az,
                        input int lat, input int hold);
        exp_t e;
        int   waited;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        e.count     = 6'(exp_cnt);
        e.all_zero  = exp_az;
        e.valid_cyc = cyc + lat;
        e.lat       = lat;
        e.hold      = hold;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Monitor: owns out_ready, compares on first valid, checks hold stability and release.
    initial begin : monitor
        exp_t cur;
        bit   tracking;
        int   hold;
        int   busy_cnt;
        tracking  = 0;
        hold      = 0;
        busy_cnt  = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tracking  = 0;
                busy_cnt  = 0;
                out_ready = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (out_valid) begin
                    if (!tracking) begin
                        if (sb.size() == 0) begin
                            fail_now("unexpected_out_valid");
                            out_ready = 1'b1;
                        end else begin
                            cur = sb[0];
                            check("out_count", 32'(out_count), 32'(cur.count));
                            check("out_all_zero", 32'(out_all_zero), 32'(cur.all_zero));
                            check("latency_cycle", cyc, cur.valid_cyc);
                            check("busy_cycles", busy_cnt, cur.lat - 1);
                            check("in_ready_in_done", 32'(in_ready), 32'd0);
                            tracking = 1;
                            hold     = cur.hold;
                        end
                    end else begin
                        check("held_count", 32'(out_count), 32'(cur.count));
                        check("held_all_zero", 32'(out_all_zero), 32'(cur.all_zero));
                        check("held_in_ready", 32'(in_ready), 32'd0);
                    end
                    if (tracking) begin
                        if (hold == 0) begin
                            out_ready = 1'b1;
                        end else begin
                            out_ready = 1'b0;
                            hold--;
                        end
                    end
                end else begin
                    if (tracking && out_ready) begin
                        check("in_ready_after_out", 32'(in_ready), 32'd1);
                        void'(sb.pop_front());
                        tracking = 0;
                        busy_cnt = 0;
                    end
                    out_ready = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout (t=%0t)", $time);
        $fatal(1, "bench timed out");
    end

    initial begin : driver
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_all_zero", 32'(out_all_zero), 32'd0);
        #9;
        rst_n = 1'b1;

        send(32'h8000_0000,  0, 1'b0, 2, 0);
        send(32'h00F0_0000,  8, 1'b0, 3, 0);
        send(32'h0000_0001, 31, 1'b0, 5, 0);
        send(32'h0000_0000, 32, 1'b1, 5, 0);
        send(32'h0000_8000, 16, 1'b0, 4, 1);
        send(32'hFFFF_FFFF,  0, 1'b0, 2, 0);
        send(32'h0001_0000, 15, 1'b0, 3, 4);
        send(32'h4000_0000,  1, 1'b0, 2, 0);

        // Abort a scan with an asynchronous reset in its second SCAN cycle.
        send(32'h0000_0001, 31, 1'b0, 5, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midscan_rst_out_valid", 32'(out_valid), 32'd0);
        check("midscan_rst_busy", 32'(busy), 32'd0);
        check("midscan_rst_out_count", 32'(out_count), 32'd0);
        check("midscan_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        send(32'h0000_0100, 23, 1'b0, 4, 0);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) fail_now("scoreboard_not_drained");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zero_count_sequencer.md
Name: zero_count_sequencer

Overview:
Multi-cycle leading-zero counter for wide words. It reuses one narrow combinational zero-counter slice and scans the word chunk by chunk, starting at the MSB end. It stops early at the first chunk that contains a one. It sits between a producer and a consumer, with a valid/ready handshake on each side, and trades latency for area on wide operands.

Parameters:
DATA_W, 32, input word width; must be a multiple of CHUNK_W.
CHUNK_W, 8, width of the chunk fed to the zero-counter slice each cycle.
N_CHUNKS, DATA_W/CHUNK_W, number of chunks (derived); must be >= 2.
OUT_W, $clog2(DATA_W+1), result width; holds 0..DATA_W.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  producer presents in_data.
in_ready  output  1  block can accept a word.
in_data  input  DATA_W  word to count.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
out_count  output  OUT_W  number of consecutive zeros from bit DATA_W-1 downward.
out_all_zero  output  1  word was entirely zero (out_count == DATA_W).
busy  output  1  state is SCAN.

Behaviour:
- Reset: rst_n low forces state IDLE immediately, asynchronously, even mid-scan.
  - out_valid=0, out_count=0, out_all_zero=0, busy=0.
  - Internal word register, chunk index and accumulator cleared.
  - in_ready=1, since it is derived from IDLE.
- FSM states: IDLE, SCAN, DONE.
- in_ready = (state==IDLE). busy = (state==SCAN). out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready: register in_data, set idx=N_CHUNKS-1 and acc=0, go to SCAN.
  - in_data is sampled only on this handshake edge.
- SCAN, one chunk per cycle:
  - cnt = leading-zero count of chunk[idx] = in_word[idx*CHUNK_W +: CHUNK_W], in range 0..CHUNK_W.
  - acc_next = acc + cnt, computed in OUT_W bits; it cannot overflow.
  - Early exit: if cnt < CHUNK_W (chunk holds a one) or idx==0, register out_count=acc_next and out_all_zero=(acc_next==DATA_W), then go to DONE.
  - Otherwise acc <= acc_next, idx <= idx-1, stay in SCAN.
- DONE:
  - out_count and out_all_zero held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
  - in_ready is 0 throughout DONE. This gives a one-cycle bubble between results, which is intended.
- Latency, counted from the accept edge to the first out_valid cycle:
  - k+1 cycles, where k = number of chunks scanned = (index from the top of the first chunk containing a one) + 1, or N_CHUNKS for a zero word.
  - Minimum 2; maximum N_CHUNKS+1.
- in_valid while not IDLE is ignored; the producer must hold it.
- out_ready while not DONE is ignored.
- Parameter check: DATA_W % CHUNK_W != 0 or N_CHUNKS < 2 is a fatal elaboration error, implemented as a generate-time $error.

Decomposition:
- Shared package zcs_pkg:
  - State enum type: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - Width helper functions for OUT_W and the chunk-count width $clog2(CHUNK_W+1).
- One sub-module: zero_counter, instantiated once with IN_W=CHUNK_W. It is the combinational slice counting zeros from the chunk MSB downward.
- Chunk mux, accumulator and FSM live in zero_count_sequencer.

Test Plan:
1. DATA_W=32, CHUNK_W=8; in_data=0x8000_0000 -> out_count=0, out_all_zero=0, out_valid 2 cycles after accept.
2. in_data=0x00F0_0000 -> out_count=8, latency 3 cycles, busy high 2 cycles.
3. in_data=0x0000_0001 -> out_count=31, latency 5 cycles (4 SCAN cycles, no early exit before idx 0).
4. in_data=0x0000_0000 -> out_count=32, out_all_zero=1, latency 5.
5. Backpressure: 0x0001_0000 with out_ready low for 4 cycles -> out_count=15 held stable, in_ready=0 throughout. After the out handshake, in_ready=1 next cycle, and a back-to-back word 0x4000_0000 yields out_count=1.
6. Reset mid-scan: accept 0x0000_0001, drop rst_n during the second SCAN cycle -> out_valid=0, busy=0, out_count=0 immediately. After release, in_ready=1 and a fresh 0x0000_0100 yields out_count=23.
